alarm_trigger: RTL and testbench
================================

// Module: alarm_trigger
// PURPOSE
// - Downstream consumer of the alarm-setting stage. Takes the stored alarm time (BCD HH:MM) and its on/off flag.
// - Compares them against the running clock time and raises the alarm.
// - Sequences ringing, stop, snooze and auto-timeout, and drives the buzzer with a 1 s on / 1 s off pattern.
// PARAMETERS
// - RING_TIMEOUT_S  60  seconds of unattended ringing before auto-stop
// - SNOOZE_MIN      5   snooze length in minutes (counted as SNOOZE_MIN*60 ticks)
// - MAX_SNOOZE      3   snoozes allowed per alarm event; further snooze presses act as stop
// PORTS
// - clk           in   1  system clock
// - rst           in   1  reset, asynchronous, active-high
// - tick_1hz      in   1  one-cycle pulse per second, synchronous to clk
// - cur_hl/cur_hr in   2/4  current hours tens/units, BCD
// - cur_ml/cur_mr in   3/4  current minutes tens/units, BCD
// - cur_sl/cur_sr in   3/4  current seconds tens/units, BCD
// - alm_hl/alm_hr in   2/4  alarm hours tens/units, from the alarm-setting stage
// - alm_ml/alm_mr in   3/4  alarm minutes tens/units
// - alarm_on      in   1  alarm enable (on_off_alarm of the setting stage)
// - alarm_edit    in   1  high while the user is editing the alarm (set_alarm_en)
// - stop_btn      in   1  one-cycle pulse, stop ringing
// - snooze_btn    in   1  one-cycle pulse, snooze
// - alarm_active  out  1  high in RINGING
// - buzzer        out  1  buzzer drive
// - snoozing      out  1  high in SNOOZE
// - snooze_cnt    out  2  snoozes used in the current event
// BEHAVIOUR
// - States:
//   - DISARMED: entered whenever alarm_on=0 or alarm_edit=1, from any state, on the next edge.
//   - ARMED: entered from DISARMED when alarm_on=1 and alarm_edit=0.
//   - RINGING and SNOOZE are described below.
// - Match:
//   - match = (cur HH:MM == alm HH:MM) && cur_sl==0 && cur_sr==0.
//   - Trigger only on the rising edge of match (match & ~match_q); match_q is registered.
// - ARMED -> RINGING:
//   - Occurs on the edge after the trigger cycle (1-cycle latency).
//   - Load ring counter = RING_TIMEOUT_S. Set buzzer phase = 1.
// - RINGING:
//   - buzzer = phase. phase toggles on each tick_1hz. Ring counter decrements on tick_1hz.
//   - Tick with counter==1 -> ARMED (timeout); snooze_cnt cleared.
//   - stop_btn -> ARMED; snooze_cnt cleared.
//   - snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; load snooze counter = SNOOZE_MIN*60.
//   - snooze_btn with snooze_cnt==MAX_SNOOZE -> treated as stop.
//   - stop_btn and snooze_btn in the same cycle: stop wins.
//   - Button pulse and timeout tick in the same cycle: the button wins.
// - SNOOZE:
//   - Snooze counter decrements on tick_1hz.
//   - Tick with counter==1 -> RINGING; ring counter and phase reloaded.
//   - stop_btn -> ARMED; snooze_cnt cleared.
// - Match edges in RINGING/SNOOZE are ignored. No retrigger after stop within the same minute (edge-based).
// - Counter width: $clog2(max(RING_TIMEOUT_S, SNOOZE_MIN*60)+1). Decrements never wrap below 0.
// - Outputs are registered. alarm_active, buzzer, snoozing are 0 outside their states.
// - Reset: state=DISARMED; all outputs, counters, match_q and phase = 0, asynchronously, mid-ring included.
// CONFIGURATION
// - ALARM_SNOOZE_EN defined: snooze behaviour as above.
// - ALARM_SNOOZE_EN undefined:
//   - snooze_btn is ignored; SNOOZE is unreachable.
//   - snoozing and snooze_cnt are tied 0; MAX_SNOOZE and SNOOZE_MIN are unused.
// STRUCTURE
// - Package alarm_pkg: state enum (DISARMED, ARMED, RINGING, SNOOZE); BCD time struct {hl, hr, ml, mr}; default timing constants.
// - Sub-module alarm_countdown: loadable down-counter with tick enable and a done pulse at 1->0.
//   - Instantiated once, shared between ring and snooze (the states are mutually exclusive).
// TESTING
// - Trigger: alarm 07:30, on. Clock steps 07:29:59 -> 07:30:00 -> alarm_active=1 and buzzer=1 one cycle later; buzzer toggles on every tick.
// - Stop: stop_btn pulse at ring tick 5 -> next edge alarm_active=0, buzzer=0, ARMED; no retrigger through 07:30:59.
// - Timeout: no buttons -> after 60 ticks alarm_active=0 and state ARMED; the next day's 07:30:00 triggers again.
// - Snooze: snooze_btn -> snoozing=1, snooze_cnt=1; after 300 ticks rings again. 4th snooze press -> ARMED, snooze_cnt=0.
// - Priority/abort:
//   - stop+snooze in the same cycle -> ARMED.
//   - alarm_on=0 mid-ring -> DISARMED next edge.
//   - alarm_edit=1 at the match instant -> no ring.
//   - rst pulse mid-ring -> outputs 0 without waiting for a clk edge.
// - Macro off: snooze_btn while ringing -> stays RINGING; snoozing stays 0.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, BCD alarm-time record and default timing constants
// for the alarm trigger block.
`default_nettype none

package alarm_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_t;

   typedef struct packed {
      logic [1:0] hl;
      logic [3:0] hr;
      logic [2:0] ml;
      logic [3:0] mr;
   } bcd_hhmm_t;

   localparam int DEF_RING_TIMEOUT_S = 60;
   localparam int DEF_SNOOZE_MIN     = 5;
   localparam int DEF_MAX_SNOOZE     = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_countdown.sv
// alarm_countdown: loadable down-counter with tick enable; o_done pulses combinationally
// on the enabled tick that takes the count from 1 to 0.
`default_nettype none

module alarm_countdown #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_tick_en,
   output logic         o_done
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_done = i_tick_en && (r_count == W'(1));

endmodule

`default_nettype wire

// File: rtl/alarm_trigger.sv
// alarm_trigger: matches clock time against the stored alarm and sequences ring/stop/snooze/timeout.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
`default_nettype none

module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int RING_TIMEOUT_S = alarm_pkg::DEF_RING_TIMEOUT_S,
   parameter int SNOOZE_MIN     = alarm_pkg::DEF_SNOOZE_MIN,
   parameter int MAX_SNOOZE     = alarm_pkg::DEF_MAX_SNOOZE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic [1:0] cur_hl,
   input  logic [3:0] cur_hr,
   input  logic [2:0] cur_ml,
   input  logic [3:0] cur_mr,
   input  logic [2:0] cur_sl,
   input  logic [3:0] cur_sr,
   input  logic [1:0] alm_hl,
   input  logic [3:0] alm_hr,
   input  logic [2:0] alm_ml,
   input  logic [3:0] alm_mr,
   input  logic       alarm_on,
   input  logic       alarm_edit,
   input  logic       stop_btn,
   input  logic       snooze_btn,
   output logic       alarm_active,
   output logic       buzzer,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);

   localparam int               CW         = $clog2(max_int(RING_TIMEOUT_S, SNOOZE_MIN * 60) + 1);
   localparam logic [CW-1:0]    C_RING_LD  = CW'(RING_TIMEOUT_S);
   localparam logic [CW-1:0]    C_SNZ_LD   = CW'(SNOOZE_MIN * 60);
   localparam logic [1:0]       C_MAX_SNZ  = 2'(MAX_SNOOZE);

`ifdef ALARM_SNOOZE_EN
   localparam logic             C_SNZ_EN   = 1'b1;
`else
   localparam logic             C_SNZ_EN   = 1'b0;
`endif

   alarm_state_t  r_state;
   logic          r_match_q;
   logic          r_active;
   logic          r_phase;
   logic          r_snoozing;
   logic [1:0]    r_snooze_cnt;

   bcd_hhmm_t     w_cur;
   bcd_hhmm_t     w_alm;
   logic          w_match;
   logic          w_trigger;
   logic          w_disarm;
   logic          w_done;
   logic          w_ring_start;
   logic          w_snooze_start;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_tick_en;

   assign w_cur     = '{hl: cur_hl, hr: cur_hr, ml: cur_ml, mr: cur_mr};
   assign w_alm     = '{hl: alm_hl, hr: alm_hr, ml: alm_ml, mr: alm_mr};
   assign w_match   = (w_cur == w_alm) && (cur_sl == 3'd0) && (cur_sr == 4'd0);
   assign w_trigger = w_match && !r_match_q;
   assign w_disarm  = !alarm_on || alarm_edit;
   assign w_tick_en = tick_1hz && ((r_state == RINGING) || (r_state == SNOOZE));

   // Counter reloads must be decided in the same cycle as the state change so no tick is lost.
   always_comb begin
      w_ring_start   = 1'b0;
      w_snooze_start = 1'b0;
      if (!w_disarm) begin
         w_ring_start   = ((r_state == ARMED) && w_trigger) ||
                          ((r_state == SNOOZE) && w_done && !stop_btn);
         w_snooze_start = C_SNZ_EN && (r_state == RINGING) && !stop_btn &&
                          snooze_btn && (r_snooze_cnt < C_MAX_SNZ);
      end
      w_load     = w_ring_start || w_snooze_start;
      w_load_val = w_snooze_start ? C_SNZ_LD : C_RING_LD;
   end

   alarm_countdown #(
      .W (CW)
   ) u_countdown (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_tick_en  (w_tick_en),
      .o_done     (w_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= DISARMED;
         r_match_q    <= 1'b0;
         r_active     <= 1'b0;
         r_phase      <= 1'b0;
         r_snoozing   <= 1'b0;
         r_snooze_cnt <= 2'd0;
      end else begin
         r_match_q <= w_match;
         if (w_disarm) begin
            r_state      <= DISARMED;
            r_active     <= 1'b0;
            r_phase      <= 1'b0;
            r_snoozing   <= 1'b0;
            r_snooze_cnt <= 2'd0;
         end else begin
            case (r_state)
               DISARMED: r_state <= ARMED;
               ARMED: begin
                  if (w_ring_start) begin
                     r_state  <= RINGING;
                     r_active <= 1'b1;
                     r_phase  <= 1'b1;
                  end
               end
               RINGING: begin
                  if (w_snooze_start) begin
                     r_state      <= SNOOZE;
                     r_active     <= 1'b0;
                     r_phase      <= 1'b0;
                     r_snoozing   <= 1'b1;
                     r_snooze_cnt <= r_snooze_cnt + 2'd1;
                  end else if (stop_btn || (C_SNZ_EN && snooze_btn) || w_done) begin
                     // Snooze past the limit behaves as stop.
                     r_state      <= ARMED;
                     r_active     <= 1'b0;
                     r_phase      <= 1'b0;
                     r_snooze_cnt <= 2'd0;
                  end else if (tick_1hz) begin
                     r_phase <= ~r_phase;
                  end
               end
               SNOOZE: begin
                  if (stop_btn) begin
                     r_state      <= ARMED;
                     r_snoozing   <= 1'b0;
                     r_snooze_cnt <= 2'd0;
                  end else if (w_ring_start) begin
                     r_state    <= RINGING;
                     r_active   <= 1'b1;
                     r_phase    <= 1'b1;
                     r_snoozing <= 1'b0;
                  end
               end
               default: r_state <= DISARMED;
            endcase
         end
      end
   end

   assign alarm_active = r_active;
   assign buzzer       = r_phase;
   assign snoozing     = r_snoozing;
   assign snooze_cnt   = r_snooze_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed stimulus for alarm_trigger with alarm 07:30; expected values hand-derived.
`default_nettype none

module tb_alarm_trigger;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic [1:0] cur_hl = 2'd0;
   logic [3:0] cur_hr = 4'd0;
   logic [2:0] cur_ml = 3'd0;
   logic [3:0] cur_mr = 4'd0;
   logic [2:0] cur_sl = 3'd0;
   logic [3:0] cur_sr = 4'd0;
   logic [1:0] alm_hl = 2'd0;
   logic [3:0] alm_hr = 4'd7;
   logic [2:0] alm_ml = 3'd3;
   logic [3:0] alm_mr = 4'd0;
   logic       alarm_on = 1'b0;
   logic       alarm_edit = 1'b0;
   logic       stop_btn = 1'b0;
   logic       snooze_btn = 1'b0;
   logic       alarm_active;
   logic       buzzer;
   logic       snoozing;
   logic [1:0] snooze_cnt;

   int total = 0;
   int bad   = 0;

   alarm_trigger dut (
      .clk          (clk),
      .rst          (rst),
      .tick_1hz     (tick_1hz),
      .cur_hl       (cur_hl),
      .cur_hr       (cur_hr),
      .cur_ml       (cur_ml),
      .cur_mr       (cur_mr),
      .cur_sl       (cur_sl),
      .cur_sr       (cur_sr),
      .alm_hl       (alm_hl),
      .alm_hr       (alm_hr),
      .alm_ml       (alm_ml),
      .alm_mr       (alm_mr),
      .alarm_on     (alarm_on),
      .alarm_edit   (alarm_edit),
      .stop_btn     (stop_btn),
      .snooze_btn   (snooze_btn),
      .alarm_active (alarm_active),
      .buzzer       (buzzer),
      .snoozing     (snoozing),
      .snooze_cnt   (snooze_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_hl = 2'(h / 10);
      cur_hr = 4'(h % 10);
      cur_ml = 3'(m / 10);
      cur_mr = 4'(m % 10);
      cur_sl = 3'(s / 10);
      cur_sr = 4'(s % 10);
   endtask

   task automatic tick();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic retrigger();
      set_time(7, 31, 0);
      cyc();
      set_time(7, 30, 0);
      cyc();
   endtask

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      cyc();
      check("rst_active", {1'b0, alarm_active}, 2'd0);
      check("rst_buzzer", {1'b0, buzzer}, 2'd0);
      check("rst_snoozing", {1'b0, snoozing}, 2'd0);
      check("rst_snzcnt", snooze_cnt, 2'd0);
      rst = 1'b0;
      alarm_on = 1'b1;
      set_time(7, 29, 59);
      cyc();
      cyc();
      check("armed_idle", {1'b0, alarm_active}, 2'd0);

      // Trigger at 07:30:00, ring one edge later
      set_time(7, 30, 0);
      cyc();
      check("trig_active", {1'b0, alarm_active}, 2'd1);
      check("trig_buzzer", {1'b0, buzzer}, 2'd1);
      tick();
      check("buz_tick1", {1'b0, buzzer}, 2'd0);
      tick();
      check("buz_tick2", {1'b0, buzzer}, 2'd1);
      ticks(3);
      check("buz_tick5", {1'b0, buzzer}, 2'd0);

      // Stop, then no retrigger within the same minute
      stop_btn = 1'b1;
      cyc();
      stop_btn = 1'b0;
      check("stop_active", {1'b0, alarm_active}, 2'd0);
      check("stop_buzzer", {1'b0, buzzer}, 2'd0);
      cyc();
      cyc();
      check("no_retrig_00", {1'b0, alarm_active}, 2'd0);
      set_time(7, 30, 59);
      cyc();
      check("no_retrig_59", {1'b0, alarm_active}, 2'd0);

      // Timeout after 60 ticks, next day retriggers
      retrigger();
      check("to_start", {1'b0, alarm_active}, 2'd1);
      ticks(59);
      check("to_tick59", {1'b0, alarm_active}, 2'd1);
      tick();
      check("to_tick60", {1'b0, alarm_active}, 2'd0);
      check("to_buzzer", {1'b0, buzzer}, 2'd0);
      retrigger();
      check("nextday", {1'b0, alarm_active}, 2'd1);

`ifdef ALARM_SNOOZE_EN
      for (int k = 1; k <= 3; k++) begin
         snooze_btn = 1'b1;
         cyc();
         snooze_btn = 1'b0;
         check("snz_active", {1'b0, alarm_active}, 2'd0);
         check("snz_flag", {1'b0, snoozing}, 2'd1);
         check("snz_cnt", snooze_cnt, 2'(k));
         ticks(299);
         check("snz_t299", {1'b0, snoozing}, 2'd1);
         tick();
         check("snz_ring", {1'b0, alarm_active}, 2'd1);
         check("snz_ringbuz", {1'b0, buzzer}, 2'd1);
      end
      snooze_btn = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      check("snz4_active", {1'b0, alarm_active}, 2'd0);
      check("snz4_flag", {1'b0, snoozing}, 2'd0);
      check("snz4_cnt", snooze_cnt, 2'd0);
      retrigger();
`else
      snooze_btn = 1'b1;
      cyc();
      snooze_btn = 1'b0;
      check("nosnz_active", {1'b0, alarm_active}, 2'd1);
      check("nosnz_flag", {1'b0, snoozing}, 2'd0);
      check("nosnz_cnt", snooze_cnt, 2'd0);
`endif

      // Stop and snooze together: stop wins
      stop_btn = 1'b1;
      snooze_btn = 1'b1;
      cyc();
      stop_btn = 1'b0;
      snooze_btn = 1'b0;
      check("both_active", {1'b0, alarm_active}, 2'd0);
      check("both_snoozing", {1'b0, snoozing}, 2'd0);

      // alarm_on dropped mid-ring
      retrigger();
      check("off_pre", {1'b0, alarm_active}, 2'd1);
      alarm_on = 1'b0;
      cyc();
      check("off_active", {1'b0, alarm_active}, 2'd0);
      check("off_buzzer", {1'b0, buzzer}, 2'd0);
      alarm_on = 1'b1;
      cyc();

      // Editing at the match instant suppresses the ring
      set_time(7, 31, 0);
      cyc();
      alarm_edit = 1'b1;
      set_time(7, 30, 0);
      cyc();
      check("edit_match", {1'b0, alarm_active}, 2'd0);
      alarm_edit = 1'b0;
      cyc();
      cyc();
      check("edit_after", {1'b0, alarm_active}, 2'd0);

      // Asynchronous reset mid-ring
      retrigger();
      check("rst_pre", {1'b0, alarm_active}, 2'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_active", {1'b0, alarm_active}, 2'd0);
      check("arst_buzzer", {1'b0, buzzer}, 2'd0);
      check("arst_cnt", snooze_cnt, 2'd0);
      cyc();
      rst = 1'b0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
